// File: rtl/inst_pkg.sv
// Shared definitions for the attention-pass instruction sequencer: instruction bit map,
// FSM state encoding (SFP states exist only with SEQ_SFP_NORM_EN) and the instruction builder.
package inst_pkg;

  localparam int INST_W = 19;

  localparam int B_SFP_DIV   = 18;
  localparam int B_SFP_ACC   = 17;
  localparam int B_OFIFO_RD  = 16;
  localparam int B_QK_ADD    = 12;
  localparam int B_P_ADD     = 8;
  localparam int B_EXECUTE   = 7;
  localparam int B_LOAD      = 6;
  localparam int B_QMEM_RD   = 5;
  localparam int B_QMEM_WR   = 4;
  localparam int B_KMEM_RD   = 3;
  localparam int B_KMEM_WR   = 2;
  localparam int B_PMEM_RD   = 1;
  localparam int B_PMEM_WR   = 0;

  typedef logic [3:0] addr_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KLOAD,
    ST_KTAIL,
    ST_GAP1,
    ST_EXEC,
    ST_GAP2,
    ST_OFIFO,
`ifdef SEQ_SFP_NORM_EN
    ST_SFP_RD,
    ST_SFP_ACC,
    ST_SFP_DIV,
    ST_SFP_WB,
`endif
    ST_DONE
  } state_t;

  // Instruction word for one cycle spent in state s at address a.
  function automatic logic [INST_W-1:0] build_inst(state_t s, addr_t a, logic k_rd);
    logic [INST_W-1:0] v;
    v = '0;
    unique case (s)
      ST_KLOAD: begin
        v[B_LOAD]          = 1'b1;
        v[B_KMEM_RD]       = k_rd;
        v[B_QK_ADD +: 4]   = a;
      end
      ST_KTAIL: v[B_LOAD] = 1'b1;
      ST_EXEC: begin
        v[B_EXECUTE]       = 1'b1;
        v[B_QMEM_RD]       = 1'b1;
        v[B_QK_ADD +: 4]   = a;
      end
      ST_OFIFO: begin
        v[B_OFIFO_RD]      = 1'b1;
        v[B_PMEM_WR]       = 1'b1;
        v[B_P_ADD +: 4]    = a;
      end
`ifdef SEQ_SFP_NORM_EN
      ST_SFP_RD: begin
        v[B_PMEM_RD]       = 1'b1;
        v[B_P_ADD +: 4]    = a;
      end
      ST_SFP_ACC: begin
        v[B_PMEM_RD]       = 1'b1;
        v[B_SFP_ACC]       = 1'b1;
        v[B_P_ADD +: 4]    = a;
      end
      ST_SFP_DIV: begin
        v[B_PMEM_RD]       = 1'b1;
        v[B_SFP_DIV]       = 1'b1;
        v[B_P_ADD +: 4]    = a;
      end
      ST_SFP_WB: begin
        v[B_PMEM_WR]       = 1'b1;
        v[B_SFP_DIV]       = 1'b1;
        v[B_P_ADD +: 4]    = a;
      end
`endif
      default: ;
    endcase
`ifndef SEQ_SFP_NORM_EN
    v[B_SFP_ACC] = 1'b0;
    v[B_SFP_DIV] = 1'b0;
`endif
    // Q and K memories are filled by an external agent, never by this sequencer.
    v[B_QMEM_WR] = 1'b0;
    v[B_KMEM_WR] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/seq_phase_cnt.sv
// Loadable down counter that times each sequencer phase; holds at zero and flags it.
// Load takes effect on the next edge; load has priority over counting.
module seq_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/inst_sequencer.sv
// Issues the fullchip instruction stream for one attention pass per start pulse; inst/busy/done
// are registered, so the first instruction follows start by one cycle. SFP normalisation needs SEQ_SFP_NORM_EN.
module inst_sequencer
  import inst_pkg::*;
#(
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap_cycles  = 10,
  parameter int div_cycles  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [INST_W-1:0] inst
);

  localparam int MAX_A   = (col + 1 > gap_cycles) ? col + 1 : gap_cycles;
  localparam int MAX_B   = (total_cycle > div_cycles) ? total_cycle : div_cycles;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  if (col < 1 || col > 16) begin : g_bad_col
    $error("inst_sequencer: col must be in 1..16");
  end
  if (total_cycle < 1 || total_cycle > 16) begin : g_bad_total
    $error("inst_sequencer: total_cycle must be in 1..16");
  end
  if (gap_cycles < 1 || div_cycles < 1) begin : g_bad_len
    $error("inst_sequencer: gap_cycles and div_cycles must be at least 1");
  end

`ifdef SEQ_SFP_NORM_EN
  localparam addr_t LAST_ROW = addr_t'(total_cycle - 1);
`endif

  state_t            r_state;
  addr_t             r_addr;
  logic [INST_W-1:0] r_inst;
  logic              r_busy;
  logic              r_done;

  state_t            w_nxt_state;
  addr_t             w_nxt_addr;
  logic              w_cnt_zero;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;

  function automatic int phase_len(state_t s);
    int n;
    unique case (s)
      ST_KLOAD:          n = col + 1;
      ST_GAP1, ST_GAP2:  n = gap_cycles;
      ST_EXEC, ST_OFIFO: n = total_cycle;
`ifdef SEQ_SFP_NORM_EN
      ST_SFP_DIV:        n = div_cycles;
`endif
      default:           n = 1;
    endcase
    return n;
  endfunction

  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (start)      w_nxt_state = ST_KLOAD;
      ST_KLOAD: if (w_cnt_zero) w_nxt_state = ST_KTAIL;
      ST_KTAIL: if (w_cnt_zero) w_nxt_state = ST_GAP1;
      ST_GAP1:  if (w_cnt_zero) w_nxt_state = ST_EXEC;
      ST_EXEC:  if (w_cnt_zero) w_nxt_state = ST_GAP2;
      ST_GAP2:  if (w_cnt_zero) w_nxt_state = ST_OFIFO;
`ifdef SEQ_SFP_NORM_EN
      ST_OFIFO:   if (w_cnt_zero) w_nxt_state = ST_SFP_RD;
      ST_SFP_RD:  if (w_cnt_zero) w_nxt_state = ST_SFP_ACC;
      ST_SFP_ACC: if (w_cnt_zero) w_nxt_state = ST_SFP_DIV;
      ST_SFP_DIV: if (w_cnt_zero) w_nxt_state = ST_SFP_WB;
      ST_SFP_WB:  if (w_cnt_zero) w_nxt_state = (r_addr == LAST_ROW) ? ST_DONE : ST_SFP_RD;
`else
      ST_OFIFO: if (w_cnt_zero) w_nxt_state = ST_DONE;
`endif
      ST_DONE:  w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase
  end

  // KLOAD holds address 0 for its first two cycles, then steps once kmem_rd is already up.
  always_comb begin
    w_nxt_addr = '0;
    unique case (w_nxt_state)
      ST_KLOAD: if (r_state == ST_KLOAD && r_inst[B_KMEM_RD]) w_nxt_addr = r_addr + 1'b1;
      ST_EXEC:  if (r_state == ST_EXEC)  w_nxt_addr = r_addr + 1'b1;
      ST_OFIFO: if (r_state == ST_OFIFO) w_nxt_addr = r_addr + 1'b1;
`ifdef SEQ_SFP_NORM_EN
      ST_SFP_RD: if (r_state == ST_SFP_WB) w_nxt_addr = r_addr + 1'b1;
      ST_SFP_ACC, ST_SFP_DIV, ST_SFP_WB: w_nxt_addr = r_addr;
`endif
      default: ;
    endcase
  end

  assign w_load     = (w_nxt_state != r_state);
  assign w_load_val = CNT_W'(phase_len(w_nxt_state) - 1);

  seq_phase_cnt #(
    .W(CNT_W)
  ) u_phase_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_zero    (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_inst  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_addr  <= w_nxt_addr;
      r_inst  <= build_inst(w_nxt_state, w_nxt_addr, r_state == ST_KLOAD);
      r_busy  <= !(w_nxt_state inside {ST_IDLE, ST_DONE});
      r_done  <= (w_nxt_state == ST_DONE);
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: each start pushes the hand-derived instruction stream,
// a negedge monitor pops and compares whenever busy or done is presented.
module tb_inst_sequencer;

  localparam int COL = 8;
  localparam int TC  = 8;
  localparam int GAP = 10;
  localparam int DIV = 3;
`ifdef SEQ_SFP_NORM_EN
  localparam int EXP_BUSY = 94;
`else
  localparam int EXP_BUSY = 46;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [18:0] inst;

  inst_sequencer #(
    .col        (COL),
    .total_cycle(TC),
    .gap_cycles (GAP),
    .div_cycles (DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .busy (busy),
    .done (done),
    .inst (inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [18:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_run = 0;
  int          last_busy_len = 0;
  int          done_cnt = 0;
  logic [18:0] obs [0:127];
`ifndef SEQ_SFP_NORM_EN
  logic [1:0]  sfp_or = 2'b00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [18:0] v, input logic b, input logic d);
    exp_t e;
    e.inst = v;
    e.busy = b;
    e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic push_pass();
    push(19'h00040, 1'b1, 1'b0);
    for (int k = 0; k < COL; k++) push(19'h00048 | (19'(k) << 12), 1'b1, 1'b0);
    push(19'h00040, 1'b1, 1'b0);
    for (int g = 0; g < GAP; g++) push(19'h00000, 1'b1, 1'b0);
    for (int a = 0; a < TC; a++) push(19'h000A0 | (19'(a) << 12), 1'b1, 1'b0);
    for (int g = 0; g < GAP; g++) push(19'h00000, 1'b1, 1'b0);
    for (int a = 0; a < TC; a++) push(19'h10001 | (19'(a) << 8), 1'b1, 1'b0);
`ifdef SEQ_SFP_NORM_EN
    for (int r = 0; r < TC; r++) begin
      push(19'h00002 | (19'(r) << 8), 1'b1, 1'b0);
      push(19'h20002 | (19'(r) << 8), 1'b1, 1'b0);
      for (int d = 0; d < DIV; d++) push(19'h40002 | (19'(r) << 8), 1'b1, 1'b0);
      push(19'h40001 | (19'(r) << 8), 1'b1, 1'b0);
    end
`endif
    push(19'h00000, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle with busy or done must match the next scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: got inst 0x%0h busy %0b done %0b, expected no output", inst, busy, done);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_inst", 32'(inst), 32'(e.inst));
          check("sb_busy", 32'(busy), 32'(e.busy));
          check("sb_done", 32'(done), 32'(e.done));
        end
        if (busy) begin
          busy_run++;
          if (busy_run < 128) obs[busy_run] = inst;
`ifndef SEQ_SFP_NORM_EN
          sfp_or = sfp_or | inst[18:17];
`endif
        end
        if (done) begin
          done_cnt++;
          last_busy_len = busy_run;
          busy_run = 0;
        end
      end else begin
        busy_run = 0;
        check("idle_inst", 32'(inst), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass();
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > d0) break;
      tick();
    end
    check("done_seen", 32'(done_cnt > d0), 32'd1);
  endtask

  int d0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // start coinciding with reset is dropped
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    repeat (5) tick();
    check("start_in_reset_busy", 32'(busy), 32'd0);

    // full pass
    d0 = done_cnt;
    run_pass();
    wait_done(d0, 300);
    check("busy_len", 32'(last_busy_len), 32'(EXP_BUSY));
    check("kload_c3", 32'(obs[3]), 32'h01048);
    check("kload_c9", 32'(obs[9]), 32'h07048);
    check("ktail", 32'(obs[10]), 32'h00040);
`ifdef SEQ_SFP_NORM_EN
    check("sfp_r5_rd", 32'(obs[77]), 32'h00502);
    check("sfp_r5_acc", 32'(obs[78]), 32'h20502);
    check("sfp_r5_div0", 32'(obs[79]), 32'h40502);
    check("sfp_r5_div1", 32'(obs[80]), 32'h40502);
    check("sfp_r5_div2", 32'(obs[81]), 32'h40502);
    check("sfp_r5_wb", 32'(obs[82]), 32'h40501);
`else
    check("sfp_bits_zero", 32'(sfp_or), 32'd0);
`endif
    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("done_once", 32'(done_cnt - d0), 32'd1);

    // start re-pulsed in busy cycle 20 is ignored
    d0 = done_cnt;
    run_pass();
    repeat (19) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, 300);
    repeat (30) tick();
    check("repulse_done_once", 32'(done_cnt - d0), 32'd1);
    check("repulse_busy_len", 32'(last_busy_len), 32'(EXP_BUSY));

    // start sampled during the done cycle is ignored
    d0 = done_cnt;
    run_pass();
    repeat (EXP_BUSY) tick();
    check("done_cycle_done", 32'(done), 32'd1);
    check("done_cycle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("start_in_done_busy", 32'(busy), 32'd0);
    check("start_in_done_cnt", 32'(done_cnt - d0), 32'd1);

    // reset in the 3rd EXEC cycle aborts without done
    d0 = done_cnt;
    run_pass();
    repeat (22) tick();
    check("exec3_inst", 32'(inst), 32'h020A0);
    reset = 1'b1;
    tick();
    check("abort_inst", 32'(inst), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    check("abort_sb_left", 32'(exp_q.size()), 32'(EXP_BUSY + 1 - 23));
    exp_q.delete();
    repeat (20) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    d0 = done_cnt;
    run_pass();
    wait_done(d0, 300);
    check("after_abort_busy_len", 32'(last_busy_len), 32'(EXP_BUSY));
    repeat (3) tick();
    check("after_abort_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter: col, default 8, number of K vectors loaded (kmem rows).
REQ-002 Parameter: total_cycle, default 8, number of Q vectors executed (qmem/pmem rows).
REQ-003 Parameter: gap_cycles, default 10, idle cycles after the K-load tail and after execute.
REQ-004 Parameter: div_cycles, default 3, sfp_div cycles before each pmem writeback.
REQ-005 Port: clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port: reset, input, 1, synchronous, active-high.
REQ-007 Port: start, input, 1, single-cycle request to run one full attention pass.
REQ-008 Port: busy, output, 1, high from the first issued instruction to the last one.
REQ-009 Port: done, output, 1, one-cycle pulse in the cycle after the last instruction.
REQ-010 Port: inst, output, 19, fullchip instruction word, registered.
REQ-011 Bit map of inst: [18] sfp_div, [17] sfp_acc, [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.

Function
REQ-012 The FSM SHALL have states IDLE, KLOAD, KTAIL, GAP1, EXEC, GAP2, OFIFO, SFP_RD, SFP_ACC, SFP_DIV, SFP_WB and DONE.
REQ-013 IDLE: inst=0 and busy=0; start=1 moves the FSM to KLOAD, and the first non-zero inst appears in the next cycle.
REQ-014 KLOAD, col+1 cycles: load=1; kmem_rd=1 from the 2nd cycle on; qkmem_add=0 for cycles 1-2, then increments by 1 per cycle, reaching col-1.
REQ-015 KTAIL, 1 cycle: load=1, kmem_rd=0, qkmem_add=0.
REQ-016 GAP1 and GAP2, gap_cycles cycles each: inst=0.
REQ-017 EXEC, total_cycle cycles: execute=1, qmem_rd=1; qkmem_add runs 0..total_cycle-1.
REQ-018 OFIFO, total_cycle cycles: ofifo_rd=1, pmem_wr=1; pmem_add runs 0..total_cycle-1.
REQ-019 SFP, per row r from 0 to total_cycle-1, with pmem_add=r throughout:
- SFP_RD, 1 cycle: pmem_rd.
- SFP_ACC, 1 cycle: pmem_rd and sfp_acc.
- SFP_DIV, div_cycles cycles: pmem_rd and sfp_div.
- SFP_WB, 1 cycle: pmem_wr and sfp_div.
- After SFP_WB, go to the next row's SFP_RD, or to DONE after the last row.
REQ-020 DONE, 1 cycle: inst=0, busy=0, done=1; then return to IDLE.
REQ-021 Read and write strobes SHALL never be high in the same cycle for the same memory (pmem_rd with pmem_wr, qmem_rd with qmem_wr).
REQ-022 qmem_wr and kmem_wr SHALL always be 0; memory writes are sourced externally.
REQ-023 start SHALL be ignored while busy=1 or done=1; no queuing.
REQ-024 Address counters SHALL be 4 bits; col and total_cycle SHALL be at most 16, checked at elaboration.
REQ-025 A single phase counter SHALL be reloaded on each state entry, and transitions SHALL occur when it reaches 0.

Reset
REQ-026 reset=1 SHALL force IDLE with inst=0, busy=0 and done=0 in the next cycle, from any state; no done pulse is produced for the aborted pass.
REQ-027 start sampled in the same cycle as reset=1 SHALL be discarded.

Configuration
REQ-028 Macro SEQ_SFP_NORM_EN: when defined, the SFP states are compiled in (REQ-019).
REQ-029 Without SEQ_SFP_NORM_EN: the FSM goes OFIFO -> DONE, sfp_acc and sfp_div are tied to 0, and the SFP states do not exist.

Structure
REQ-030 Package inst_pkg SHALL hold: the inst bit-position constants, the INST_W=19 constant, the state enum typedef, and the 4-bit address typedef.
REQ-031 One sub-module, seq_phase_cnt (loadable down counter with a zero flag), SHALL be instantiated once.

Verification
REQ-032 Defaults with SEQ_SFP_NORM_EN, start pulse -> busy high for exactly 94 cycles (9+1+10+8+10+8+48), then done high for 1 cycle.
REQ-033 Same run without the macro -> busy high for exactly 46 cycles; inst[18:17]=0 throughout.
REQ-034 KLOAD check -> 3rd KLOAD cycle has kmem_rd=1, qkmem_add=1; 9th cycle has qkmem_add=7; KTAIL has inst=0x00040.
REQ-035 SFP row 5 -> six consecutive cycles with pmem_add=5: inst 0x00502, 0x20502, 0x40502, 0x40502, 0x40502, 0x40501.
REQ-036 reset asserted in the 3rd EXEC cycle -> inst=0 and busy=0 on the next edge; a later start gives a full 94-cycle pass.
REQ-037 start re-pulsed in the 20th busy cycle -> ignored; done pulses exactly once.
